// File: rtl/bcd_entry_ctrl.sv
// Keypad-to-BCD-adder sequencer: synchronises key events, builds two BCD operands,
// then walks the external 1-digit adder LSD first and shows entry/result on disp.
module bcd_entry_ctrl #(
    parameter int NDIG = 2
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic [4:0]            key_code,
    input  logic                  key_strobe,
    output logic [3:0]            add_a,
    output logic [3:0]            add_b,
    output logic                  add_cin,
    input  logic [3:0]            add_s,
    input  logic                  add_cout,
    output logic [4*(NDIG+1)-1:0] disp,
    output logic                  busy,
    output logic                  done
);

    localparam int OW = 4 * NDIG;
    localparam int RW = 4 * (NDIG + 1);
    localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;

    localparam logic [4:0] K_PLUS  = 5'd10;
    localparam logic [4:0] K_EQUAL = 5'd11;
    localparam logic [4:0] K_CLEAR = 5'd12;

    typedef enum logic [1:0] {
        ST_ENTRY_A,
        ST_ENTRY_B,
        ST_ADD,
        ST_DONE
    } state_t;

    state_t          r_state;
    logic            r_strobeS1, r_strobeS2, r_strobeS3;
    logic [4:0]      r_codeS1, r_codeS2;
    logic [OW-1:0]   r_opa, r_opb;
    logic [RW-1:0]   r_result;
    logic            r_carry;
    logic [IW-1:0]   r_idx;

    state_t          w_nextState;
    logic [OW-1:0]   w_nextOpa, w_nextOpb, w_digit;
    logic [RW-1:0]   w_nextResult, w_nextDisp;
    logic            w_nextCarry, w_event, w_isDigit;
    logic [IW-1:0]   w_nextIdx;

    assign w_event   = r_strobeS2 & ~r_strobeS3;
    assign w_isDigit = (r_codeS2 <= 5'd9);
    assign w_digit   = {{(OW-4){1'b0}}, r_codeS2[3:0]};

    // Next-state logic; outputs are registered from these next values so they line up with the state.
    always_comb begin
        w_nextState  = r_state;
        w_nextOpa    = r_opa;
        w_nextOpb    = r_opb;
        w_nextResult = r_result;
        w_nextCarry  = r_carry;
        w_nextIdx    = r_idx;
        case (r_state)
            ST_ENTRY_A: begin
                if (w_event && w_isDigit) begin
                    w_nextOpa = (r_opa << 4) | w_digit;
                end else if (w_event && r_codeS2 == K_PLUS) begin
                    w_nextOpb   = '0;
                    w_nextState = ST_ENTRY_B;
                end
            end
            ST_ENTRY_B: begin
                if (w_event && w_isDigit) begin
                    w_nextOpb = (r_opb << 4) | w_digit;
                end else if (w_event && r_codeS2 == K_EQUAL) begin
                    w_nextIdx   = '0;
                    w_nextCarry = 1'b0;
                    w_nextState = ST_ADD;
                end
            end
            ST_ADD: begin
                w_nextResult[4*r_idx +: 4] = add_s;
                w_nextCarry                = add_cout;
                if (r_idx == IW'(NDIG - 1)) begin
                    w_nextResult[RW-1 -: 4] = {3'b000, add_cout};
                    w_nextState             = ST_DONE;
                end else begin
                    w_nextIdx = r_idx + 1'b1;
                end
            end
            ST_DONE: begin
                if (w_event && w_isDigit) begin
                    w_nextOpa   = w_digit;
                    w_nextOpb   = '0;
                    w_nextState = ST_ENTRY_A;
                end else if (w_event && r_codeS2 == K_PLUS) begin
                    w_nextOpa   = r_result[OW-1:0];
                    w_nextOpb   = '0;
                    w_nextState = ST_ENTRY_B;
                end
            end
            default: w_nextState = ST_ENTRY_A;
        endcase
        // Clear wins over everything, including an addition in flight.
        if (w_event && r_codeS2 == K_CLEAR) begin
            w_nextOpa    = '0;
            w_nextOpb    = '0;
            w_nextResult = '0;
            w_nextCarry  = 1'b0;
            w_nextIdx    = '0;
            w_nextState  = ST_ENTRY_A;
        end
    end

    always_comb begin
        case (w_nextState)
            ST_ENTRY_A:      w_nextDisp = {4'h0, w_nextOpa};
            ST_DONE:         w_nextDisp = w_nextResult;
            default:         w_nextDisp = {4'h0, w_nextOpb};
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state    <= ST_ENTRY_A;
            r_strobeS1 <= 1'b0;
            r_strobeS2 <= 1'b0;
            r_strobeS3 <= 1'b0;
            r_codeS1   <= '0;
            r_codeS2   <= '0;
            r_opa      <= '0;
            r_opb      <= '0;
            r_result   <= '0;
            r_carry    <= 1'b0;
            r_idx      <= '0;
            disp       <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            add_a      <= '0;
            add_b      <= '0;
            add_cin    <= 1'b0;
        end else begin
            r_strobeS1 <= key_strobe;
            r_strobeS2 <= r_strobeS1;
            r_strobeS3 <= r_strobeS2;
            r_codeS1   <= key_code;
            r_codeS2   <= r_codeS1;
            r_state    <= w_nextState;
            r_opa      <= w_nextOpa;
            r_opb      <= w_nextOpb;
            r_result   <= w_nextResult;
            r_carry    <= w_nextCarry;
            r_idx      <= w_nextIdx;
            disp       <= w_nextDisp;
            busy       <= (w_nextState == ST_ADD);
            done       <= (w_nextState == ST_DONE) && (r_state != ST_DONE);
            // Adder operands track the digit that will be captured on the following edge.
            if (w_nextState == ST_ADD) begin
                add_a   <= w_nextOpa[4*w_nextIdx +: 4];
                add_b   <= w_nextOpb[4*w_nextIdx +: 4];
                add_cin <= w_nextCarry;
            end else begin
                add_a   <= '0;
                add_b   <= '0;
                add_cin <= 1'b0;
            end
        end
    end

endmodule
